dm_sb_arbiter: RTL

- Shares the single system-bus master port among NrPorts debug requesters: SBA engine, program-buffer fetch, trace-dump engine.
- Uses round-robin arbitration with one outstanding transaction at a time.
- Routes the response back to the requester that issued the transaction.
- Guards against a hung bus with a response timeout that returns an error to the requester.

---
 rtl/dm_pkg.sv | 12 +
 rtl/dm_rr_pick.sv | 32 +++
 rtl/dm_sb_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared types for the debug-module system-bus logic.
package dm_pkg;

    // States of the system-bus arbiter.
    typedef enum logic [1:0] {
        Idle,
        Lock,
        Wait,
        Drain
    } sb_arb_state_e;

endpackage

// File: rtl/dm_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request
// found scanning upward from ptr_i+1 with wrap-around.
module dm_rr_pick #(
    parameter int unsigned NrIn = 2,
    localparam int unsigned IdxW = (NrIn > 1) ? $clog2(NrIn) : 1
) (
    input  logic [NrIn-1:0] req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;

    // Scan from the farthest candidate down so the nearest one after ptr_i wins.
    always_comb begin
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = int'(NrIn); i >= 1; i--) begin
            cand     = (32'(ptr_i) + 32'(i)) % NrIn;
            cand_idx = IdxW'(cand);
            if (req_i[cand_idx]) begin
                idx_o   = cand_idx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dm_sb_arbiter.sv
// Round-robin arbiter sharing the system-bus master port between debug
// requesters, one outstanding transaction at a time, with response timeout.
module dm_sb_arbiter
    import dm_pkg::*;
#(
    parameter int unsigned BusWidth      = 32,
    parameter int unsigned NrPorts       = 2,
    parameter int unsigned TimeoutCycles = 1024,
    localparam int unsigned IdxW         = $clog2(NrPorts)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 dmactive_i,
    input  logic [NrPorts-1:0]                   req_i,
    input  logic [NrPorts-1:0][BusWidth-1:0]     add_i,
    input  logic [NrPorts-1:0]                   we_i,
    input  logic [NrPorts-1:0][BusWidth-1:0]     wdata_i,
    input  logic [NrPorts-1:0][BusWidth/8-1:0]   be_i,
    output logic [NrPorts-1:0]                   gnt_o,
    output logic [NrPorts-1:0]                   r_valid_o,
    output logic [BusWidth-1:0]                  r_rdata_o,
    output logic                                 r_err_o,
    output logic                                 master_req_o,
    output logic [BusWidth-1:0]                  master_add_o,
    output logic                                 master_we_o,
    output logic [BusWidth-1:0]                  master_wdata_o,
    output logic [BusWidth/8-1:0]                master_be_o,
    input  logic                                 master_gnt_i,
    input  logic                                 master_r_valid_i,
    input  logic [BusWidth-1:0]                  master_r_rdata_i,
    output logic                                 busy_o,
    output logic [IdxW-1:0]                      owner_o
);

    localparam int unsigned TimerW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TimerW-1:0] TimerLast =
        TimerW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);
    localparam logic [IdxW-1:0] PtrInit = IdxW'(NrPorts - 1);

    sb_arb_state_e     state_q, state_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [TimerW-1:0] timer_inc;
    logic [IdxW-1:0]   pick_idx;
    logic              pick_valid;
    logic              timeout_hit;

    dm_rr_pick #(
        .NrIn (NrPorts)
    ) i_rr_pick (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign timer_inc   = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    assign timeout_hit = (TimeoutCycles != 0) && (timer_q == TimerLast);
    assign busy_o      = (state_q != Idle);
    assign owner_o     = owner_q;

    // Next-state, bus steering and response routing.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        timer_d        = timer_q;
        gnt_o          = '0;
        r_valid_o      = '0;
        r_rdata_o      = '0;
        r_err_o        = 1'b0;
        master_req_o   = 1'b0;
        master_add_o   = '0;
        master_we_o    = 1'b0;
        master_wdata_o = '0;
        master_be_o    = '0;
        if (!dmactive_i) begin
            state_d  = Idle;
            rr_ptr_d = PtrInit;
            owner_d  = '0;
            timer_d  = '0;
        end else begin
            unique case (state_q)
                Idle: begin
                    if (pick_valid) begin
                        master_req_o    = 1'b1;
                        master_add_o    = add_i[pick_idx];
                        master_we_o     = we_i[pick_idx];
                        master_wdata_o  = wdata_i[pick_idx];
                        master_be_o     = be_i[pick_idx];
                        gnt_o[pick_idx] = master_gnt_i;
                        owner_d         = pick_idx;
                        if (master_gnt_i) begin
                            timer_d = '0;
                            state_d = Wait;
                        end else begin
                            state_d = Lock;
                        end
                    end
                end
                Lock: begin
                    master_req_o   = req_i[owner_q];
                    master_add_o   = add_i[owner_q];
                    master_we_o    = we_i[owner_q];
                    master_wdata_o = wdata_i[owner_q];
                    master_be_o    = be_i[owner_q];
                    if (!req_i[owner_q]) begin
                        state_d = Idle;
                    end else if (master_gnt_i) begin
                        gnt_o[owner_q] = 1'b1;
                        timer_d        = '0;
                        state_d        = Wait;
                    end
                end
                Wait: begin
                    timer_d = timer_inc;
                    if (master_r_valid_i) begin
                        r_valid_o[owner_q] = 1'b1;
                        r_rdata_o          = master_r_rdata_i;
                        rr_ptr_d           = owner_q;
                        state_d            = Idle;
                    end else if (timeout_hit) begin
                        r_valid_o[owner_q] = 1'b1;
                        r_err_o            = 1'b1;
                        rr_ptr_d           = owner_q;
                        timer_d            = '0;
                        state_d            = Drain;
                    end
                end
                Drain: begin
                    timer_d = timer_inc;
                    if (master_r_valid_i || timeout_hit) begin
                        state_d = Idle;
                    end
                end
                default: state_d = Idle;
            endcase
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= Idle;
            rr_ptr_q <= PtrInit;
            owner_q  <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            timer_q  <= timer_d;
        end
    end

    // A locked requester must hold its request until the bus grants it.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == Lock && dmactive_i) |-> req_i[owner_q]);

endmodule
